// File: rtl/cnu_msg_gen.sv
// Check-node message generator: captures one check node's min/min2/min_idx/sign state and
// emits its D check-to-variable messages serially, through a two-entry (active/pending) buffer.
module cnu_msg_gen #(
    parameter int unsigned data_w = 8,
    parameter int unsigned idx_w  = 8,
    parameter int unsigned D      = 5,
    parameter int unsigned OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] min,
    input  logic [data_w-1:0] min2,
    input  logic [idx_w-1:0]  min_idx,
    input  logic [D-1:0]      in_sgn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sgn,
    output logic [data_w-1:0] out_mag,
    output logic [idx_w-1:0]  out_idx,
    output logic              out_last
);

    localparam logic [idx_w-1:0]  LastIdx = idx_w'(D - 1);
    localparam logic [data_w-1:0] Offset  = data_w'(OFFSET);

    logic              a_full_q, a_full_d, p_full_q, p_full_d;
    logic [idx_w-1:0]  cnt_q, cnt_d;
    logic [data_w-1:0] a_min_q, a_min_d, a_min2_q, a_min2_d, p_min_q, p_min_d, p_min2_q, p_min2_d;
    logic [idx_w-1:0]  a_idx_q, a_idx_d, p_idx_q, p_idx_d;
    logic [D-1:0]      a_sgn_q, a_sgn_d, p_sgn_q, p_sgn_d;
    logic              a_par_q, a_par_d, p_par_q, p_par_d;

    logic              in_fire, out_fire, last_fire;
    logic [data_w-1:0] sel;
    logic [D-1:0]      sgn_shift;

    assign in_ready  = !p_full_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = a_full_q && out_ready;
    assign last_fire = out_fire && (cnt_q == LastIdx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_full_q <= 1'b0;
            p_full_q <= 1'b0;
            cnt_q    <= '0;
            a_min_q  <= '0;
            a_min2_q <= '0;
            a_idx_q  <= '0;
            a_sgn_q  <= '0;
            a_par_q  <= 1'b0;
            p_min_q  <= '0;
            p_min2_q <= '0;
            p_idx_q  <= '0;
            p_sgn_q  <= '0;
            p_par_q  <= 1'b0;
        end else begin
            a_full_q <= a_full_d;
            p_full_q <= p_full_d;
            cnt_q    <= cnt_d;
            a_min_q  <= a_min_d;
            a_min2_q <= a_min2_d;
            a_idx_q  <= a_idx_d;
            a_sgn_q  <= a_sgn_d;
            a_par_q  <= a_par_d;
            p_min_q  <= p_min_d;
            p_min2_q <= p_min2_d;
            p_idx_q  <= p_idx_d;
            p_sgn_q  <= p_sgn_d;
            p_par_q  <= p_par_d;
        end
    end

    always_comb begin
        a_full_d = a_full_q;
        p_full_d = p_full_q;
        cnt_d    = cnt_q;
        a_min_d  = a_min_q;
        a_min2_d = a_min2_q;
        a_idx_d  = a_idx_q;
        a_sgn_d  = a_sgn_q;
        a_par_d  = a_par_q;
        p_min_d  = p_min_q;
        p_min2_d = p_min2_q;
        p_idx_d  = p_idx_q;
        p_sgn_d  = p_sgn_q;
        p_par_d  = p_par_q;

        if (last_fire) begin
            cnt_d = '0;
            if (p_full_q) begin
                // in_ready was low, so no input can collide with the P-to-A move
                a_min_d  = p_min_q;
                a_min2_d = p_min2_q;
                a_idx_d  = p_idx_q;
                a_sgn_d  = p_sgn_q;
                a_par_d  = p_par_q;
                p_full_d = 1'b0;
            end else if (in_fire) begin
                a_min_d  = min;
                a_min2_d = min2;
                a_idx_d  = min_idx;
                a_sgn_d  = in_sgn;
                a_par_d  = ^in_sgn;
            end else begin
                a_full_d = 1'b0;
            end
        end else begin
            if (out_fire) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (in_fire) begin
                if (!a_full_q) begin
                    a_full_d = 1'b1;
                    cnt_d    = '0;
                    a_min_d  = min;
                    a_min2_d = min2;
                    a_idx_d  = min_idx;
                    a_sgn_d  = in_sgn;
                    a_par_d  = ^in_sgn;
                end else begin
                    p_full_d = 1'b1;
                    p_min_d  = min;
                    p_min2_d = min2;
                    p_idx_d  = min_idx;
                    p_sgn_d  = in_sgn;
                    p_par_d  = ^in_sgn;
                end
            end
        end
    end

    // Outputs depend only on registered A state, so they hold while stalled.
    always_comb begin
        sel       = (cnt_q == a_idx_q) ? a_min2_q : a_min_q;
        sgn_shift = a_sgn_q >> cnt_q;
        out_valid = a_full_q;
        out_mag   = (sel > Offset) ? sel - Offset : '0;
        out_sgn   = a_par_q ^ sgn_shift[0];
        out_idx   = cnt_q;
        out_last  = (cnt_q == LastIdx);
    end

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Randomized self-checking bench for cnu_msg_gen against a queue-based message model.
module tb_cnu_msg_gen;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int D = 5;
    localparam int OFFSET = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] min = '0;
    logic [DW-1:0] min2 = '0;
    logic [IW-1:0] min_idx = '0;
    logic [D-1:0]  in_sgn = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sgn;
    logic [DW-1:0] out_mag;
    logic [IW-1:0] out_idx;
    logic          out_last;

    cnu_msg_gen #(.data_w(DW), .idx_w(IW), .D(D), .OFFSET(OFFSET)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .min      (min),
        .min2     (min2),
        .min_idx  (min_idx),
        .in_sgn   (in_sgn),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sgn  (out_sgn),
        .out_mag  (out_mag),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sgn;
        logic [DW-1:0] mag;
        logic [IW-1:0] idx;
        logic          last;
    } msg_t;

    msg_t exp_q[$];
    int   inflight = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic msg_t ref_msg(input int mn, input int mn2, input int mi,
                                     input logic [D-1:0] s, input int j);
        msg_t m;
        int   sel;
        int   par;
        par = 0;
        for (int k = 0; k < D; k++) par = par + int'((s >> k) & 1);
        sel    = (j == mi) ? mn2 : mn;
        m.mag  = DW'((sel > OFFSET) ? sel - OFFSET : 0);
        m.sgn  = 1'((par + int'((s >> j) & 1)) % 2);
        m.idx  = IW'(j);
        m.last = (j == D - 1);
        return m;
    endfunction

    task automatic push_node(input int mn, input int mn2, input int mi, input logic [D-1:0] s);
        for (int j = 0; j < D; j++) exp_q.push_back(ref_msg(mn, mn2, mi, s, j));
        inflight++;
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run_random(input int ncycles, input int vpct, input int rpct);
        logic stalled;
        msg_t held;
        logic in_fire, out_fire;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < ncycles; c++) begin
            in_valid  = ($urandom_range(0, 99) < vpct);
            out_ready = ($urandom_range(0, 99) < rpct);
            min       = DW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom_range(0, 255));
            min2      = DW'($urandom_range(0, 255));
            min_idx   = IW'($urandom_range(0, 7));
            in_sgn    = D'($urandom);
            @(negedge clk);
            check_eq("out_valid", 32'(out_valid), 32'(inflight > 0));
            check_eq("in_ready", 32'(in_ready), 32'(inflight < 2));
            if (stalled) check_eq("stable", 32'({out_sgn, out_mag, out_idx, out_last}), 32'(held));
            if (out_valid && exp_q.size() > 0) begin
                check_eq("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
                check_eq("out_mag", 32'(out_mag), 32'(exp_q[0].mag));
                check_eq("out_sgn", 32'(out_sgn), 32'(exp_q[0].sgn));
                check_eq("out_last", 32'(out_last), 32'(exp_q[0].last));
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            stalled  = out_valid && !out_ready;
            held     = {out_sgn, out_mag, out_idx, out_last};
            @(posedge clk);
            if (out_fire && exp_q.size() > 0) begin
                if (exp_q[0].last) inflight--;
                void'(exp_q.pop_front());
            end
            if (in_fire) push_node(int'(min), int'(min2), int'(min_idx), in_sgn);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [D-1:0] s_tab [3];
        int mn_tab [3];
        int mn2_tab [3];
        int mi_tab [3];
        logic [0:4] sgn_exp;
        int mag_exp [5];

        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_mag", 32'(out_mag), 32'd0);
        check_eq("rst_out_idx", 32'(out_idx), 32'd0);
        check_eq("rst_out_sgn_last", 32'({out_sgn, out_last}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single node with fixed expected values.
        sgn_exp = 5'b10100;
        mag_exp = '{2, 2, 6, 2, 2};
        in_valid = 1'b1; min = 8'd3; min2 = 8'd7; min_idx = 8'd2; in_sgn = 5'b00101;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("single_valid", 32'(out_valid), 32'd1);
            check_eq("single_idx", 32'(out_idx), 32'(k));
            check_eq("single_sgn", 32'(out_sgn), 32'(sgn_exp[k]));
            check_eq("single_mag", 32'(out_mag), 32'(mag_exp[k]));
            check_eq("single_last", 32'(out_last), 32'(k == 4));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_eq("single_done", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Directed corner nodes through the model, back-to-back with full throughput.
        mn_tab  = '{0, 4, 5};
        mn2_tab = '{1, 9, 6};
        mi_tab  = '{0, 5, 4};
        s_tab   = '{5'b11111, 5'b00001, 5'b10110};
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            min = DW'(mn_tab[n]); min2 = DW'(mn2_tab[n]); min_idx = IW'(mi_tab[n]);
            in_sgn = s_tab[n];
            @(negedge clk);
            check_eq("b2b_in_ready", 32'(in_ready), 32'(inflight < 2));
            while (!in_ready) begin
                check_eq("b2b_valid", 32'(out_valid), 32'd1);
                check_eq("b2b_mag", 32'(out_mag), 32'(exp_q[0].mag));
                check_eq("b2b_sgn", 32'(out_sgn), 32'(exp_q[0].sgn));
                @(posedge clk);
                if (exp_q[0].last) inflight--;
                void'(exp_q.pop_front());
                #1;
                @(negedge clk);
            end
            check_eq("b2b_idx", 32'(out_valid ? out_idx : 8'd0), 32'(exp_q.size() > 0 ? exp_q[0].idx : 8'd0));
            @(posedge clk);
            if (out_valid && exp_q.size() > 0) begin
                if (exp_q[0].last) inflight--;
                void'(exp_q.pop_front());
            end
            push_node(mn_tab[n], mn2_tab[n], mi_tab[n], s_tab[n]);
            #1;
        end
        run_random(40, 0, 100);

        run_random(300, 60, 60);
        run_random(150, 100, 100);
        run_random(150, 90, 30);

        // Reset mid-emission: immediate clear, nothing reappears after release.
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_mag", 32'(out_mag), 32'd0);
        exp_q.delete();
        inflight = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("post_rst_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        run_random(300, 50, 70);
        run_random(60, 0, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
